// File: rtl/div_arbiter_pkg.sv
// Shared definitions for the two-requester divider arbiter.
// Holds the FSM encoding, requester count, flush length and datapath widths,
// plus the latched-request record handed to the divider.
package div_arbiter_pkg;

   localparam int NUM_REQ      = 2;
   localparam int FLUSH_CYCLES = 2;
   localparam int DATA_W       = 32;
   localparam int RES_W        = 64;

   // Counter width for the post-annul quiet period; at least one bit.
   localparam int FLUSH_CNT_W  = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUSY  = 2'd1,
      DONE  = 2'd2,
      FLUSH = 2'd3
   } state_t;

   // Operands captured at grant time; the divider only ever sees these.
   typedef struct packed {
      logic              sgn;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
   } div_req_t;

endpackage

// File: rtl/div_arbiter_rr_arb2.sv
// Two-request round-robin arbiter with a pointer that moves only on a grant.
// Ports: clk/rst (sync, active-high); req = eligible requests; en = grants allowed
// this cycle; gnt = one-hot grant (combinational). Pointer resets to favour req 0.
module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       en,
   output logic [1:0] gnt
);

   // prio_q names the requester that wins the next tie.
   logic prio_q;

   always_comb begin
      gnt = 2'b00;
      if (en) begin
         unique case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
            default: gnt = 2'b00;
         endcase
      end
   end

   // After granting requester n, the other one becomes preferred.
   always_ff @(posedge clk) begin
      if (rst) begin
         prio_q <= 1'b0;
      end else if (|gnt) begin
         prio_q <= ~gnt[1];
      end
   end

endmodule

// File: rtl/div_arbiter.sv
// Shares one iterative divider between two pipeline requesters.
// Requester side: req_valid_i/req_signed_i/req_op1_i/req_op2_i/req_annul_i in,
//   req_done_o (1-cycle pulse), req_stall_o (combinational), result_o {rem, quo}.
// Divider side: div_signed_o/div_op1_o/div_op2_o (registered), div_start_o,
//   div_annul_o out; div_result_i, div_ready_i in. clk, rst sync active-high.
module div_arbiter
   import div_arbiter_pkg::*;
(
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_REQ-1:0]              req_valid_i,
   input  logic [NUM_REQ-1:0]              req_signed_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_op1_i,
   input  logic [NUM_REQ-1:0][DATA_W-1:0]  req_op2_i,
   input  logic [NUM_REQ-1:0]              req_annul_i,
   output logic [NUM_REQ-1:0]              req_done_o,
   output logic [NUM_REQ-1:0]              req_stall_o,
   output logic [RES_W-1:0]                result_o,
   output logic                            div_signed_o,
   output logic [DATA_W-1:0]               div_op1_o,
   output logic [DATA_W-1:0]               div_op2_o,
   output logic                            div_start_o,
   output logic                            div_annul_o,
   input  logic [RES_W-1:0]                div_result_i,
   input  logic                            div_ready_i
);

   state_t                 state_q, state_d;
   logic                   owner_q;
   div_req_t               lat_q;
   logic [RES_W-1:0]       result_q;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q;

   logic [NUM_REQ-1:0]     eligible;
   logic [NUM_REQ-1:0]     gnt;
   logic                   arb_en;
   logic                   gnt_any;
   logic                   gnt_idx;
   logic                   owner_annul;
   logic                   capture;
   logic                   flush_last;

   // A requester that is aborting in the same cycle is not worth starting.
   assign eligible    = req_valid_i & ~req_annul_i;

   // Grants only from IDLE: DONE must show the divider a low start first.
   assign arb_en      = (state_q == IDLE);
   assign gnt_any     = |gnt;
   assign gnt_idx     = gnt[1];

   // Only the current owner may abort an operation; the other annul is ignored.
   assign owner_annul = req_annul_i[owner_q];
   assign flush_last  = (flush_cnt_q == FLUSH_CNT_W'(FLUSH_CYCLES - 1));

   rr_arb2 u_arb (
      .clk (clk),
      .rst (rst),
      .req (eligible),
      .en  (arb_en),
      .gnt (gnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      div_start_o = 1'b0;
      div_annul_o = 1'b0;
      req_done_o  = '0;
      capture     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d = BUSY;
            end
         end

         BUSY: begin
            // Annul wins over a coincident ready: no pulse, result untouched.
            if (owner_annul) begin
               div_annul_o = 1'b1;
               state_d     = FLUSH;
            end else begin
               div_start_o = 1'b1;
               if (div_ready_i) begin
                  req_done_o[owner_q] = 1'b1;
                  capture             = 1'b1;
                  state_d             = DONE;
               end
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         FLUSH: begin
            // Quiet period that also drags a divider out of a div-by-zero or
            // end state before the next start.
            if (flush_last) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath registers: operands are sampled only on a grant, so requester
   // inputs never reach the divider combinationally or while BUSY.
   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q     <= 1'b0;
         lat_q       <= '0;
         result_q    <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (gnt_any) begin
            owner_q   <= gnt_idx;
            lat_q.sgn <= req_signed_i[gnt_idx];
            lat_q.op1 <= req_op1_i[gnt_idx];
            lat_q.op2 <= req_op2_i[gnt_idx];
         end

         if (capture) begin
            result_q <= div_result_i;
         end

         if (state_q == FLUSH) begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
         end else begin
            flush_cnt_q <= '0;
         end
      end
   end

   assign div_signed_o = lat_q.sgn;
   assign div_op1_o    = lat_q.op1;
   assign div_op2_o    = lat_q.op2;
   assign result_o     = result_q;

   assign req_stall_o  = req_valid_i & ~req_done_o & ~req_annul_i;

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: a behavioural divider with a chosen
// latency, a transaction-level reference (round-robin winner, quotient/remainder
// by plain arithmetic, per-cycle timing from the stated latencies), random traffic.
module tb_div_arbiter;
   import div_arbiter_pkg::*;

   logic                           clk = 1'b0;
   logic                           rst;
   logic [NUM_REQ-1:0]             req_valid;
   logic [NUM_REQ-1:0]             req_signed;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_op1;
   logic [NUM_REQ-1:0][DATA_W-1:0] req_op2;
   logic [NUM_REQ-1:0]             req_annul;
   logic [NUM_REQ-1:0]             req_done;
   logic [NUM_REQ-1:0]             req_stall;
   logic [RES_W-1:0]               result;
   logic                           div_signed;
   logic [DATA_W-1:0]              div_op1;
   logic [DATA_W-1:0]              div_op2;
   logic                           div_start;
   logic                           div_annul;
   logic [RES_W-1:0]               div_result;
   logic                           div_ready;

   div_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid_i  (req_valid),
      .req_signed_i (req_signed),
      .req_op1_i    (req_op1),
      .req_op2_i    (req_op2),
      .req_annul_i  (req_annul),
      .req_done_o   (req_done),
      .req_stall_o  (req_stall),
      .result_o     (result),
      .div_signed_o (div_signed),
      .div_op1_o    (div_op1),
      .div_op2_o    (div_op2),
      .div_start_o  (div_start),
      .div_annul_o  (div_annul),
      .div_result_i (div_result),
      .div_ready_i  (div_ready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Truncating division; a zero divisor yields an all-zero result.
   function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, q, r;
      if (b == 32'd0) return 64'd0;
      if (s) begin
         sa = $signed(a);
         sb = $signed(b);
      end else begin
         sa = {32'd0, a};
         sb = {32'd0, b};
      end
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction

   // Behavioural divider: ready once start has been high for lat cycles.
   int lat  = 1;
   int dcnt = 0;
   initial begin
      div_ready  = 1'b0;
      div_result = '0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !div_start) begin
            dcnt      = 0;
            div_ready = 1'b0;
         end else begin
            dcnt++;
            div_ready = (dcnt >= lat);
         end
         div_result = ref_div(div_signed, div_op1, div_op2);
      end
   end

   // Reference state.
   int          rr_pref;
   bit          pend  [2];
   logic        p_sgn [2];
   logic [31:0] p_op1 [2];
   logic [31:0] p_op2 [2];
   logic [63:0] last_res;

   task automatic drive();
      for (int n = 0; n < 2; n++) begin
         req_valid[n]  = pend[n];
         req_signed[n] = p_sgn[n];
         req_op1[n]    = p_op1[n];
         req_op2[n]    = p_op2[n];
      end
   endtask

   task automatic set_req(input int n, input logic s, input logic [31:0] a,
                          input logic [31:0] b);
      pend[n]  = 1'b1;
      p_sgn[n] = s;
      p_op1[n] = a;
      p_op2[n] = b;
   endtask

   task automatic new_rand_req(input int n);
      logic [31:0] a, b;
      a = $urandom;
      case ($urandom_range(0, 3))
         0:       b = 32'd0;
         1:       b = $urandom_range(1, 9);
         2:       b = 32'hFFFF_FFFF - $urandom_range(0, 5);
         default: b = $urandom;
      endcase
      set_req(n, 1'(($urandom_range(0, 1))), a, b);
   endtask

   task automatic check_stall(input string tag, input logic [1:0] exp_done);
      logic [1:0] exp_st;
      for (int n = 0; n < 2; n++)
         exp_st[n] = req_valid[n] & ~exp_done[n] & ~req_annul[n];
      chk(tag, req_stall, exp_st);
   endtask

   // Called just after a negedge with the DUT in IDLE; returns just after the
   // negedge that begins the next IDLE cycle.
   task automatic run_txn(input int L, input int annul_at, input bit poke);
      int          w, o;
      logic [63:0] exp;
      logic [1:0]  exp_done;
      bit          fin;
      w = (pend[0] && pend[1]) ? rr_pref : (pend[0] ? 0 : 1);
      o = 1 - w;
      rr_pref = o;
      exp = ref_div(p_sgn[w], p_op1[w], p_op2[w]);
      lat = L;
      req_annul = '0;
      drive();
      #1;
      chk("grant_cycle_start", div_start, 0);
      chk("grant_cycle_done", req_done, 0);
      check_stall("grant_cycle_stall", 2'b00);
      fin = 0;
      for (int c = 1; c <= L && !fin; c++) begin
         @(negedge clk);
         req_annul = '0;
         if (poke && c == 1 && !pend[o]) req_annul[o] = 1'b1;
         if (c == annul_at) req_annul[w] = 1'b1;
         #1;
         exp_done = '0;
         if (c == L && c != annul_at) exp_done[w] = 1'b1;
         chk("busy_start", div_start, (c != annul_at));
         chk("busy_annul", div_annul, (c == annul_at));
         chk("busy_done", req_done, exp_done);
         check_stall("busy_stall", exp_done);
         if (c == 1) begin
            chk("latched_op1", div_op1, p_op1[w]);
            chk("latched_op2", div_op2, p_op2[w]);
            chk("latched_signed", div_signed, p_sgn[w]);
         end
         if (c == annul_at) begin
            fin = 1;
            for (int f = 1; f <= FLUSH_CYCLES; f++) begin
               @(negedge clk);
               pend[w] = 0;
               req_annul = '0;
               drive();
               #1;
               chk("flush_start", div_start, 0);
               chk("flush_annul", div_annul, 0);
               chk("flush_done", req_done, 0);
            end
            chk("annul_result_kept", result, last_res);
         end else if (c == L) begin
            fin = 1;
            @(negedge clk);
            pend[w] = 0;
            req_annul = '0;
            drive();
            #1;
            chk("done_state_start", div_start, 0);
            chk("done_state_pulse", req_done, 0);
            chk("result", result, exp);
            last_res = exp;
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      for (int n = 0; n < 2; n++) pend[n] = 0;
      req_annul = '0;
      drive();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      rr_pref  = 0;
      last_res = '0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (limit 2000000)");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      for (int n = 0; n < 2; n++) begin
         pend[n] = 0; p_sgn[n] = 0; p_op1[n] = '0; p_op2[n] = '0;
      end
      req_annul = '0;
      drive();
      rr_pref  = 0;
      last_res = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("reset_start", div_start, 0);
      chk("reset_annul", div_annul, 0);
      chk("reset_done", req_done, 0);
      chk("reset_result", result, 0);
      chk("reset_op1", div_op1, 0);
      chk("reset_op2", div_op2, 0);
      chk("reset_signed", div_signed, 0);
      @(negedge clk);

      // 100/7 unsigned.
      set_req(0, 1'b0, 32'd100, 32'd7);
      run_txn(5, 0, 0);
      #1;
      chk("div_100_7", result, {32'd2, 32'd14});

      // Tie after reset: req0 first, then signed -7/2 on req1.
      do_reset();
      set_req(0, 1'b0, 32'd20, 32'd3);
      set_req(1, 1'b1, 32'hFFFF_FFF9, 32'd2);
      run_txn(3, 0, 0);
      #1;
      chk("tie_first_req0", result, {32'd2, 32'd6});
      run_txn(4, 0, 0);
      #1;
      chk("signed_m7_2", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

      // Divide by zero, then a clean restart.
      set_req(0, 1'b0, 32'd5, 32'd0);
      run_txn(2, 0, 0);
      #1;
      chk("div_by_zero", result, 64'd0);
      set_req(0, 1'b0, 32'd9, 32'd4);
      run_txn(6, 0, 0);
      #1;
      chk("after_div0", result, {32'd1, 32'd2});

      // Owner annul 10 cycles into BUSY, then a fresh request.
      set_req(1, 1'b0, 32'd1234, 32'd10);
      run_txn(14, 10, 0);
      set_req(0, 1'b0, 32'd50, 32'd6);
      run_txn(3, 0, 0);
      #1;
      chk("after_annul", result, {32'd2, 32'd8});

      // Annul coincident with divider ready.
      set_req(1, 1'b1, 32'd77, 32'd3);
      run_txn(4, 4, 0);

      // Valid together with annul in IDLE is not eligible.
      req_valid = 2'b10;
      req_annul = 2'b10;
      #1;
      chk("idle_annul_stall", req_stall, 2'b00);
      @(negedge clk);
      #1;
      chk("idle_annul_no_grant", div_start, 0);
      req_annul = '0;
      drive();
      @(negedge clk);

      // Random traffic.
      for (int it = 0; it < 60; it++) begin
         int L, ann;
         for (int n = 0; n < 2; n++)
            if (!pend[n] && $urandom_range(0, 1) == 1) new_rand_req(n);
         if (!pend[0] && !pend[1]) new_rand_req(int'($urandom_range(0, 1)));
         L   = $urandom_range(1, 12);
         ann = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, L)) : 0;
         run_txn(L, ann, bit'($urandom_range(0, 1)));
      end
      // Drain anything left pending.
      while (pend[0] || pend[1]) run_txn(2, 0, 0);

      // Reset in the middle of BUSY on a req0 operation.
      set_req(0, 1'b0, 32'd77, 32'd5);
      lat = 8;
      drive();
      repeat (3) @(negedge clk);
      rst = 1'b1;
      pend[0] = 0;
      drive();
      @(negedge clk);
      rst = 1'b0;
      rr_pref  = 0;
      last_res = '0;
      #1;
      chk("midrst_start", div_start, 0);
      chk("midrst_annul", div_annul, 0);
      chk("midrst_done", req_done, 0);
      chk("midrst_result", result, 0);
      chk("midrst_op1", div_op1, 0);
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         #1;
         chk("midrst_no_late_done", req_done, 0);
      end
      @(negedge clk);
      // Pointer must favour req0 again after reset.
      set_req(0, 1'b0, 32'd81, 32'd9);
      set_req(1, 1'b0, 32'd64, 32'd8);
      run_txn(2, 0, 0);
      #1;
      chk("post_rst_tie_req0", result, {32'd0, 32'd9});
      run_txn(2, 0, 0);
      #1;
      chk("post_rst_req1", result, {32'd0, 32'd8});

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
